// File: rtl/data_sram_initiator_pkg.sv
// Shared definitions for the data-side SRAM-like bus initiator: FSM states and
// data_size encodings used by both the initiator and the bus-side logic.
package data_sram_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    localparam logic [1:0] DATA_SIZE_BYTE = 2'd0;
    localparam logic [1:0] DATA_SIZE_HALF = 2'd1;
    localparam logic [1:0] DATA_SIZE_WORD = 2'd2;

    // Natural alignment: halves on even addresses, words on multiples of 4.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == DATA_SIZE_HALF) && addr_lo[0]) ||
               ((size == DATA_SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/data_sram_initiator_sel_to_size.sv
// Byte-lane select to bus transfer size; vld is low for lane patterns that do
// not form a naturally aligned byte, half or word (size then reads as word).
module data_sram_initiator_sel_to_size
    import data_sram_initiator_pkg::*;
(
    input  logic [3:0] sel,
    output logic [1:0] size,
    output logic       vld
);

    always_comb begin
        size = DATA_SIZE_WORD;
        vld  = 1'b0;
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                size = DATA_SIZE_BYTE;
                vld  = 1'b1;
            end
            4'b0011, 4'b1100: begin
                size = DATA_SIZE_HALF;
                vld  = 1'b1;
            end
            4'b1111: begin
                size = DATA_SIZE_WORD;
                vld  = 1'b1;
            end
            default: begin
                size = DATA_SIZE_WORD;
                vld  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/data_sram_initiator.sv
// MEM-stage initiator for the data SRAM-like bus: one outstanding req/addr_ok/data_ok
// transaction, stalls MEM until done. Define DATA_ADDR_CHECK_EN to flag misaligned accesses.
module data_sram_initiator
    import data_sram_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_flag,
    input  logic                  mem_write_flag,
    input  logic [3:0]            mem_sel,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  flush,
    input  logic                  pipeline_stall,
    output logic                  stall_request,
    output logic [DATA_WIDTH-1:0] ram_read_data,
    output logic                  address_error,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [DATA_WIDTH-1:0] data_wdata,
    input  logic                  data_addr_ok,
    input  logic [DATA_WIDTH-1:0] data_rdata,
    input  logic                  data_data_ok
);

    state_e                state_q, state_d;
    logic                  kill_q, kill_d;
    logic                  load_q, load_d;
    logic                  wr_q, wr_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic       access;
    logic [1:0] sel_size;
    logic       sel_vld;
    logic       addr_err;
    logic       issue;
    logic       req_int;
    logic       stall_int;
    logic       bypass;

    data_sram_initiator_sel_to_size u_sel_to_size (
        .sel  (mem_sel),
        .size (sel_size),
        .vld  (sel_vld)
    );

    assign access = mem_read_flag | mem_write_flag;

`ifdef DATA_ADDR_CHECK_EN
    assign addr_err = sel_vld & misaligned(sel_size, mem_addr[1:0]);
`else
    assign addr_err = 1'b0;
`endif

    assign issue = (state_q == ST_IDLE) & access & sel_vld & ~flush & ~addr_err;

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        load_d    = load_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        req_int   = 1'b0;
        stall_int = 1'b0;
        bypass    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    req_int   = 1'b1;
                    stall_int = 1'b1;
                    kill_d    = 1'b0;
                    // A set write flag wins when both flags are raised.
                    wr_d      = mem_write_flag;
                    load_d    = ~mem_write_flag;
                    size_d    = sel_size;
                    addr_d    = mem_addr;
                    wdata_d   = mem_write_data;
                    state_d   = data_addr_ok ? ST_WAIT_DATA : ST_WAIT_ADDR;
                end
            end
            ST_WAIT_ADDR: begin
                req_int   = 1'b1;
                stall_int = 1'b1;
                if (flush) kill_d = 1'b1;
                if (data_addr_ok) state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (data_data_ok) begin
                    kill_d = 1'b0;
                    if (kill_q | flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        if (load_q) begin
                            bypass  = 1'b1;
                            rdata_d = data_rdata;
                        end
                        state_d = pipeline_stall ? ST_DONE : ST_IDLE;
                    end
                end else begin
                    stall_int = 1'b1;
                    if (flush) kill_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (flush | ~pipeline_stall) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            kill_q  <= 1'b0;
            load_q  <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= DATA_SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            load_q  <= load_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // In IDLE the request goes out straight from the MEM stage; afterwards it is frozen.
    assign data_req      = rst & req_int;
    assign data_wr       = (state_q == ST_IDLE) ? mem_write_flag : wr_q;
    assign data_size     = (state_q == ST_IDLE) ? sel_size       : size_q;
    assign data_addr     = (state_q == ST_IDLE) ? mem_addr       : addr_q;
    assign data_wdata    = (state_q == ST_IDLE) ? mem_write_data : wdata_q;
    assign stall_request = rst & stall_int;
    assign address_error = rst & (state_q == ST_IDLE) & access & addr_err;
    assign ram_read_data = bypass ? data_rdata : rdata_q;

endmodule

// File: tb/tb_data_sram_initiator.sv
// Directed cycle-by-cycle vector table plus hand-written sequences for the
// misaligned access and reset-in-flight cases.
module tb_data_sram_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_flag, mem_write_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_write_data;
    logic        flush, pipeline_stall;
    logic        stall_request;
    logic [31:0] ram_read_data;
    logic        address_error;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_sram_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_flag  (mem_read_flag),
        .mem_write_flag (mem_write_flag),
        .mem_sel        (mem_sel),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .flush          (flush),
        .pipeline_stall (pipeline_stall),
        .stall_request  (stall_request),
        .ram_read_data  (ram_read_data),
        .address_error  (address_error),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_addr_ok   (data_addr_ok),
        .data_rdata     (data_rdata),
        .data_data_ok   (data_data_ok)
    );

    typedef struct {
        logic        rst, rd, wr;
        logic [3:0]  sel;
        logic [31:0] addr, wdata;
        logic        fl, ps, aok, dok;
        logic [31:0] rdata;
        logic        e_req, e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata;
        logic        e_stall;
        logic [31:0] e_rrd;
    } vec_t;

    function automatic vec_t v(
        input logic rst_i, rd, wr, input logic [3:0] sel, input logic [31:0] addr, wdata,
        input logic fl, ps, aok, dok, input logic [31:0] rdata,
        input logic e_req, e_wr, input logic [1:0] e_size, input logic [31:0] e_addr, e_wdata,
        input logic e_stall, input logic [31:0] e_rrd);
        vec_t r;
        r.rst = rst_i; r.rd = rd; r.wr = wr; r.sel = sel; r.addr = addr; r.wdata = wdata;
        r.fl = fl; r.ps = ps; r.aok = aok; r.dok = dok; r.rdata = rdata;
        r.e_req = e_req; r.e_wr = e_wr; r.e_size = e_size; r.e_addr = e_addr;
        r.e_wdata = e_wdata; r.e_stall = e_stall; r.e_rrd = e_rrd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        rst = x.rst; mem_read_flag = x.rd; mem_write_flag = x.wr; mem_sel = x.sel;
        mem_addr = x.addr; mem_write_data = x.wdata; flush = x.fl; pipeline_stall = x.ps;
        data_addr_ok = x.aok; data_data_ok = x.dok; data_rdata = x.rdata;
    endtask

    vec_t tbl[25];
    vec_t idle_v;

    initial begin
        idle_v = v(1,0,0,4'hF,32'h0,32'h0, 0,0,0,0,32'h0, 0,0,2'd0,32'h0,32'h0, 0,32'h0);

        // Reset forces outputs low even with a request pending at the inputs.
        tbl[0]  = v(0,1,0,4'hF,32'h1000,0, 0,0,1,0,0,          0,0,0,0,0,              0,32'h0);
        tbl[1]  = v(1,0,0,4'hF,32'h1000,0, 0,0,0,0,0,          0,0,0,0,0,              0,32'h0);
        // Word load, minimum latency.
        tbl[2]  = v(1,1,0,4'hF,32'h1000,0, 0,0,1,0,0,          1,0,2,32'h1000,0,       1,32'h0);
        tbl[3]  = v(1,1,0,4'hF,32'h1000,0, 0,0,0,1,32'hDEADBEEF, 0,0,0,0,0,            0,32'hDEADBEEF);
        tbl[4]  = v(1,0,0,4'hF,32'h1000,0, 0,0,0,0,0,          0,0,0,0,0,              0,32'hDEADBEEF);
        // Byte store, addr_ok after 3 wait cycles; MEM inputs wiggle to prove the request is frozen.
        tbl[5]  = v(1,0,1,4'h4,32'h2002,32'h00AB0000, 0,0,0,0,0, 1,1,0,32'h2002,32'h00AB0000, 1,32'hDEADBEEF);
        tbl[6]  = v(1,0,1,4'hF,32'h3000,32'h11111111, 0,0,0,0,0, 1,1,0,32'h2002,32'h00AB0000, 1,32'hDEADBEEF);
        tbl[7]  = v(1,0,1,4'hF,32'h3000,32'h11111111, 0,0,0,0,0, 1,1,0,32'h2002,32'h00AB0000, 1,32'hDEADBEEF);
        tbl[8]  = v(1,0,1,4'hF,32'h3000,32'h11111111, 0,0,1,0,0, 1,1,0,32'h2002,32'h00AB0000, 1,32'hDEADBEEF);
        tbl[9]  = v(1,0,1,4'hF,32'h3000,32'h11111111, 0,0,0,0,0, 0,0,0,0,0,            1,32'hDEADBEEF);
        tbl[10] = v(1,0,1,4'hF,32'h3000,32'h11111111, 0,0,0,1,32'h55555555, 0,0,0,0,0, 0,32'hDEADBEEF);
        tbl[11] = idle_v; tbl[11].e_rrd = 32'hDEADBEEF;
        // Half load completing under pipeline_stall: DONE for 3 cycles, no reissue.
        tbl[12] = v(1,1,0,4'h3,32'h1002,0, 0,0,1,0,0,          1,0,1,32'h1002,0,       1,32'hDEADBEEF);
        tbl[13] = v(1,1,0,4'h3,32'h1002,0, 0,1,0,1,32'hCAFE0000, 0,0,0,0,0,            0,32'hCAFE0000);
        tbl[14] = v(1,1,0,4'h3,32'h1002,0, 0,1,1,0,0,          0,0,0,0,0,              0,32'hCAFE0000);
        tbl[15] = v(1,1,0,4'h3,32'h1002,0, 0,1,1,0,0,          0,0,0,0,0,              0,32'hCAFE0000);
        tbl[16] = v(1,1,0,4'h3,32'h1002,0, 0,0,1,0,0,          0,0,0,0,0,              0,32'hCAFE0000);
        tbl[17] = idle_v; tbl[17].e_rrd = 32'hCAFE0000;
        // Flush while waiting for data: drained, result discarded.
        tbl[18] = v(1,1,0,4'hF,32'h1004,0, 0,0,1,0,0,          1,0,2,32'h1004,0,       1,32'hCAFE0000);
        tbl[19] = v(1,1,0,4'hF,32'h1004,0, 1,0,0,0,0,          0,0,0,0,0,              1,32'hCAFE0000);
        tbl[20] = idle_v; tbl[20].e_stall = 1'b1; tbl[20].e_rrd = 32'hCAFE0000;
        tbl[21] = v(1,0,0,4'hF,32'h0,0, 0,0,0,1,32'h12345678,  0,0,0,0,0,              0,32'hCAFE0000);
        tbl[22] = idle_v; tbl[22].e_rrd = 32'hCAFE0000;
        // Flush in IDLE and an illegal lane pattern both suppress the request.
        tbl[23] = v(1,1,0,4'hF,32'h1000,0, 1,0,1,0,0,          0,0,0,0,0,              0,32'hCAFE0000);
        tbl[24] = v(1,1,0,4'h5,32'h1000,0, 0,0,1,0,0,          0,0,0,0,0,              0,32'hCAFE0000);

        drive(tbl[0]);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i]);
            #4;
            check($sformatf("row%0d data_req", i),      {31'b0, data_req},      {31'b0, tbl[i].e_req});
            check($sformatf("row%0d stall_request", i), {31'b0, stall_request}, {31'b0, tbl[i].e_stall});
            check($sformatf("row%0d ram_read_data", i), ram_read_data,          tbl[i].e_rrd);
            check($sformatf("row%0d address_error", i), {31'b0, address_error}, 32'h0);
            if (tbl[i].e_req) begin
                check($sformatf("row%0d data_wr", i),    {31'b0, data_wr},   {31'b0, tbl[i].e_wr});
                check($sformatf("row%0d data_size", i),  {30'b0, data_size}, {30'b0, tbl[i].e_size});
                check($sformatf("row%0d data_addr", i),  data_addr,          tbl[i].e_addr);
                check($sformatf("row%0d data_wdata", i), data_wdata,         tbl[i].e_wdata);
            end
            @(posedge clk);
            #1;
        end

        // Misaligned half load at 0x1001.
        drive(v(1,1,0,4'h3,32'h1001,0, 0,0,1,0,0, 0,0,0,0,0, 0,0));
        #4;
`ifdef DATA_ADDR_CHECK_EN
        check("misal address_error", {31'b0, address_error}, 32'h1);
        check("misal data_req",      {31'b0, data_req},      32'h0);
        check("misal stall",         {31'b0, stall_request}, 32'h0);
        @(posedge clk); #1;
        drive(idle_v);
        #4;
        check("misal after req",     {31'b0, data_req},      32'h0);
        check("misal after stall",   {31'b0, stall_request}, 32'h0);
`else
        check("misal address_error", {31'b0, address_error}, 32'h0);
        check("misal data_req",      {31'b0, data_req},      32'h1);
        check("misal data_size",     {30'b0, data_size},     32'h1);
        check("misal data_addr",     data_addr,              32'h1001);
        check("misal stall",         {31'b0, stall_request}, 32'h1);
        @(posedge clk); #1;
        drive(v(1,0,0,4'hF,32'h0,0, 0,0,0,1,32'hBEEF0000, 0,0,0,0,0, 0,0));
        #4;
        check("misal data_ok stall", {31'b0, stall_request}, 32'h0);
        check("misal data_ok rdata", ram_read_data,          32'hBEEF0000);
`endif
        @(posedge clk); #1;

        // Reset while waiting for addr_ok.
        drive(v(1,1,0,4'hF,32'h1008,0, 0,0,0,0,0, 0,0,0,0,0, 0,0));
        #4;
        check("rstmid issue req", {31'b0, data_req}, 32'h1);
        @(posedge clk); #1;
        #4;
        check("rstmid wait req",  {31'b0, data_req}, 32'h1);
        check("rstmid wait addr", data_addr,         32'h1008);
        rst = 1'b0;
        #1;
        check("rstmid forced req",   {31'b0, data_req},      32'h0);
        check("rstmid forced stall", {31'b0, stall_request}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_read_flag = 1'b0;
        #4;
        check("rstmid after req",   {31'b0, data_req},      32'h0);
        check("rstmid after stall", {31'b0, stall_request}, 32'h0);
        check("rstmid after rdata", ram_read_data,          32'h0);
        // Back in IDLE: a new load goes out from the live MEM address.
        mem_read_flag = 1'b1;
        mem_addr      = 32'h2000;
        #1;
        check("rstmid reissue req",  {31'b0, data_req}, 32'h1);
        check("rstmid reissue addr", data_addr,         32'h2000);
        @(posedge clk); #1;
        drive(idle_v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_sram_initiator.md
# data_sram_initiator

MEM-stage initiator for the data-side SRAM-like bus. It turns a MEM-stage load or store into a req/addr_ok/data_ok transaction and stalls the pipeline until the transaction completes. It returns the read word toward the MEM/WB boundary and holds it while downstream stalls keep the instruction in MEM. It sits between the MEM stage and the data-memory/cache port.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width (`ADDR_BUS_WIDTH`)
- DATA_WIDTH, 32, data width (`DATA_BUS_WIDTH`)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- mem_read_flag  in  1  MEM-stage instruction is a load
- mem_write_flag  in  1  MEM-stage instruction is a store
- mem_sel  in  4  byte-lane select from MEM stage
- mem_addr  in  ADDR_WIDTH  byte address
- mem_write_data  in  DATA_WIDTH  store data, already lane-positioned
- flush  in  1  exception/flush kills the MEM-stage instruction
- pipeline_stall  in  1  MEM held by another stall source
- stall_request  out  1  MEM-stage stall request
- ram_read_data  out  DATA_WIDTH  load data toward MEM/WB
- address_error  out  1  misaligned access (macro only)
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  ADDR_WIDTH  bus address
- data_wdata  out  DATA_WIDTH  bus write data
- data_addr_ok  in  1  request accepted
- data_rdata  in  DATA_WIDTH  read data
- data_data_ok  in  1  data phase complete

## Operation
- access = mem_read_flag | mem_write_flag. If both flags are set, treat the access as a write.
- States:
  - IDLE: no transaction.
  - WAIT_ADDR: request raised, waiting for addr_ok.
  - WAIT_DATA: request accepted, waiting for data_ok.
  - DONE: access completed; instruction still held in MEM.
- IDLE → issue when access & !flush & !addr_err. Drive data_req in the same cycle.
  - If data_addr_ok is seen that cycle → WAIT_DATA.
  - Otherwise → WAIT_ADDR.
- WAIT_ADDR: data_req held with addr/size/wr/wdata frozen from issue-time registers. Move to WAIT_DATA on data_addr_ok.
- WAIT_DATA: on data_data_ok, capture data_rdata into ram_read_data (loads only).
  - Next state is DONE if pipeline_stall, else IDLE.
- DONE: no request issued. Move to IDLE when pipeline_stall = 0.
- flush:
  - In IDLE or DONE: suppresses or ends the access; go to IDLE.
  - In WAIT_ADDR or WAIT_DATA: the bus transaction still drains. Set a kill flag and discard the result (no ram_read_data update), then go to IDLE. stall_request stays asserted until drain completes.
- data_size encoding from mem_sel:
  - one-hot → 0.
  - 0011 or 1100 → 1.
  - 1111 → 2.
  - Any other value → 2 with data_req suppressed (treated as no access).
- Never more than one outstanding transaction.

## Timing
- Reset (rst = 0 at edge): state IDLE, ram_read_data 0, kill flag 0. While reset is applied, data_req, stall_request and address_error are forced 0.
- stall_request:
  - 1 in IDLE-with-issue, WAIT_ADDR, and WAIT_DATA-without-data_ok.
  - 0 in the data_ok cycle, in DONE, and in IDLE without issue.
- In the data_ok cycle, ram_read_data bypasses data_rdata combinationally. From the next cycle on, the registered copy is driven.
- Minimum load latency: addr_ok in the issue cycle and data_ok one cycle later gives exactly 1 stall cycle.
- addr_ok and data_ok in the same cycle while in WAIT_ADDR is illegal (the bus guarantees it never happens).
- Reset mid-transaction: abort to IDLE, drop data_req. The bus is reset jointly.

## Configuration
- DATA_ADDR_CHECK_EN defined:
  - addr_err = (size 1 & addr[0]) | (size 2 & addr[1:0] ≠ 0).
  - On addr_err in IDLE: address_error = 1 combinationally, no request, no stall.
- Undefined: address_error tied 0, addr_err = 0, addresses passed unchecked.

## Structure
- Shared header (with bus.v): state encoding and the DATA_SIZE_BYTE/HALF/WORD constants.
- One sub-module: sel_to_size (mem_sel → data_size plus a valid bit).

## Test plan
- Word load, addr 0x1000, addr_ok in the issue cycle, data_ok next cycle with 0xDEADBEEF → 1 stall cycle; ram_read_data = 0xDEADBEEF, held afterward.
- Byte store, sel 0100, data 0x00AB0000, addr_ok delayed 3 cycles → data_req held 4 cycles with size 0 and wr 1 stable; stall until data_ok.
- Load completes while pipeline_stall = 1 for 3 more cycles → DONE, no second data_req, ram_read_data held, IDLE when pipeline_stall drops.
- flush in WAIT_DATA, then data_ok with 0x12345678 → ram_read_data unchanged (previous value), stall low after data_ok, IDLE.
- Half load at addr 0x1001 with DATA_ADDR_CHECK_EN → address_error = 1, data_req = 0, stall = 0. Without the macro → request issued with size 1.
- rst = 0 asserted in WAIT_ADDR → next cycle IDLE, data_req 0, ram_read_data 0.
